// File: rtl/ram_fifo_ctrl.sv
// ram_fifo_ctrl: synchronous FIFO controller in front of the 32-entry
// full-duplex RAM. Owns write/read pointers, occupancy and flags, and maps a
// push/pop handshake onto the RAM wr/rd controls. Read data returns one cycle
// after a pop accept, qualified by pop_valid.
//
// Optional build macro FIFO_WATERMARK_EN adds registered almost_full /
// almost_empty outputs driven from AF_LEVEL / AE_LEVEL.
//
// The RAM clears memory[waddr] on every cycle that has neither a write nor a
// read, so the write pointer must always point at a free slot. That caps
// occupancy at DEPTH-1.

module ram_fifo_ctrl #(
    parameter int DW       = 16,
    parameter int AW       = 5,
    parameter int AF_LEVEL = 28,
    parameter int AE_LEVEL = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    output logic          push_ready,
    input  logic          pop,
    output logic          pop_ready,
    output logic          pop_valid,
    output logic [DW-1:0] pop_data,
    output logic [AW-1:0] count,
    output logic          full,
    output logic          empty,
`ifdef FIFO_WATERMARK_EN
    output logic          almost_full,
    output logic          almost_empty,
`endif
    output logic          ram_wr,
    output logic [AW-1:0] ram_waddr,
    output logic [DW-1:0] ram_d_in,
    output logic          ram_rd,
    output logic [AW-1:0] ram_raddr,
    input  logic [DW-1:0] ram_d_out
);

    localparam int              DEPTH     = 2 ** AW;
    localparam logic [AW-1:0]   MAX_COUNT = AW'(DEPTH - 1);

`ifdef FIFO_WATERMARK_EN
    localparam logic [AW-1:0]   AF_THRESH = AW'(AF_LEVEL);
    localparam logic [AW-1:0]   AE_THRESH = AW'(AE_LEVEL);
`endif

    // Read-return pipeline: a pop accepted this cycle means RAM data next cycle.
    typedef enum logic {
        IDLE         = 1'b0,
        READ_PENDING = 1'b1
    } rd_state_e;

    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW-1:0] count_q, count_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;
    rd_state_e     rd_state_q, rd_state_d;
`ifdef FIFO_WATERMARK_EN
    logic          almost_full_q, almost_full_d;
    logic          almost_empty_q, almost_empty_d;
`endif

    logic push_fire;
    logic pop_fire;

    // Handshake: push wins the RAM port, so an accepted push blocks pop.
    always_comb begin
        push_fire = push & ~full_q & ~rst;
        pop_ready = ~empty_q & ~push_fire;
        pop_fire  = pop & pop_ready & ~rst;
    end

    // Next-state for pointers, occupancy, flags and the read pipeline bit.
    always_comb begin
        // NOTE: every signal assigned here gets a default first; a path that
        // leaves one unassigned would infer a latch.
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        count_d    = count_q;
        rd_state_d = IDLE;

        if (push_fire) begin
            wptr_d  = wptr_q + 1'b1;
            count_d = count_q + 1'b1;
        end else if (pop_fire) begin
            rptr_d     = rptr_q + 1'b1;
            count_d    = count_q - 1'b1;
            rd_state_d = READ_PENDING;
        end

        full_d  = (count_d == MAX_COUNT);
        empty_d = (count_d == '0);
`ifdef FIFO_WATERMARK_EN
        almost_full_d  = (count_d >= AF_THRESH);
        almost_empty_d = (count_d <= AE_THRESH);
`endif
    end

    // State registers; synchronous reset dominates any request in that cycle.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge value of its neighbours.
        if (rst) begin
            wptr_q         <= '0;
            rptr_q         <= '0;
            count_q        <= '0;
            full_q         <= 1'b0;
            empty_q        <= 1'b1;
            rd_state_q     <= IDLE;
`ifdef FIFO_WATERMARK_EN
            almost_full_q  <= 1'b0;
            almost_empty_q <= 1'b1;
`endif
        end else begin
            wptr_q         <= wptr_d;
            rptr_q         <= rptr_d;
            count_q        <= count_d;
            full_q         <= full_d;
            empty_q        <= empty_d;
            rd_state_q     <= rd_state_d;
`ifdef FIFO_WATERMARK_EN
            almost_full_q  <= almost_full_d;
            almost_empty_q <= almost_empty_d;
`endif
        end
    end

    // Output mapping.
    always_comb begin
        push_ready = ~full_q;
        pop_valid  = (rd_state_q == READ_PENDING);
        pop_data   = pop_valid ? ram_d_out : '0;
        count      = count_q;
        full       = full_q;
        empty      = empty_q;
        ram_wr     = push_fire;
        ram_waddr  = wptr_q;
        ram_d_in   = push_data;
        ram_rd     = pop_fire;
        ram_raddr  = rptr_q;
`ifdef FIFO_WATERMARK_EN
        almost_full  = almost_full_q;
        almost_empty = almost_empty_q;
`endif
    end

endmodule
